// File: rtl/compare_pkg.sv
// ---------------------------------------------------------------------------
// compare_pkg
// Shared types and elaboration helpers for the sequential magnitude
// comparator (compare_seq) and its digit cell (compare_digit).
//   state_e      : controller states
//   num_digits   : number of DIGIT-wide digits in a WIDTH-bit operand
//   cnt_width    : digit counter width, never narrower than 1 bit
//   params_ok    : WIDTH/DIGIT legality
// ---------------------------------------------------------------------------
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage : compare_pkg

// File: rtl/compare_digit.sv
// ---------------------------------------------------------------------------
// compare_digit
// Combinational unsigned compare of one DIGIT-bit slice; the multi-bit
// form of the old single-bit compare cell. Equality is !gt && !lt.
// Ports:
//   a, b : DIGIT-bit digits to compare
//   gt   : a > b
//   lt   : a < b
// ---------------------------------------------------------------------------
module compare_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    gt = (a > b);
    lt = (a < b);
  end

endmodule : compare_digit

// File: rtl/compare_seq.sv
// ---------------------------------------------------------------------------
// compare_seq
// Sequential magnitude comparator. Examines DIGIT bits per cycle, MSB first,
// optionally stopping at the first differing digit. Signed compare is done
// by flipping both sign bits at load so that the unsigned digit walk yields
// two's-complement order.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; flags hold the last result
// RUN   | one digit examined per cycle, first difference recorded
// DONE  | flags valid, done pulsed for this single cycle
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, honoured only while busy = 0
//   signed_mode  : 1 = two's-complement compare (sampled with start)
//   a, b         : WIDTH-bit operands (sampled with start)
//   busy         : high in RUN and DONE
//   done         : one-cycle result-valid pulse
//   eq, gt, lt   : registered result flags, exactly one high after done
// ---------------------------------------------------------------------------
module compare_seq
  import compare_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("compare_seq: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             diff_found_q, diff_found_d;
  logic             diff_gt_q, diff_gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic dig_gt;
  logic dig_lt;
  logic dig_diff;

  compare_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a  (a_sh_q[WIDTH-1 -: DIGIT]),
    .b  (b_sh_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  assign dig_diff = dig_gt | dig_lt;

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    diff_found_d = diff_found_q;
    diff_gt_d    = diff_gt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    eq_d         = eq_q;
    gt_d         = gt_q;
    lt_d         = lt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          a_sh_d       = signed_mode ? (a ^ MSB_MASK) : a;
          b_sh_d       = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_d        = CNT_LOAD;
          diff_found_d = 1'b0;
          diff_gt_d    = 1'b0;
          busy_d       = 1'b1;
          eq_d         = 1'b0;
          gt_d         = 1'b0;
          lt_d         = 1'b0;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q << DIGIT;
        b_sh_d = b_sh_q << DIGIT;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        // Only the most significant difference decides the order.
        if (!diff_found_q && dig_diff) begin
          diff_found_d = 1'b1;
          diff_gt_d    = dig_gt;
        end
        if ((cnt_q == '0) || (EARLY_EXIT && dig_diff)) begin
          state_d = DONE;
          done_d  = 1'b1;
          eq_d    = ~diff_found_d;
          gt_d    = diff_found_d & diff_gt_d;
          lt_d    = diff_found_d & ~diff_gt_d;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      diff_found_q <= 1'b0;
      diff_gt_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      eq_q         <= 1'b0;
      gt_q         <= 1'b0;
      lt_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      diff_found_q <= diff_found_d;
      diff_gt_q    <= diff_gt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      eq_q         <= eq_d;
      gt_q         <= gt_d;
      lt_q         <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule : compare_seq

// File: tb/tb_compare_seq.sv
// ---------------------------------------------------------------------------
// tb_compare_seq
// Three comparator instances share operands and reset:
//   0 : WIDTH=8 DIGIT=1 EARLY_EXIT=1
//   1 : WIDTH=8 DIGIT=1 EARLY_EXIT=0
//   2 : WIDTH=8 DIGIT=4 EARLY_EXIT=1
// Expected flags and done cycle are queued when start is driven and
// compared when the instance raises done.
// ---------------------------------------------------------------------------
module tb_compare_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       signed_mode;
  logic [7:0] a, b;
  logic [2:0] start_v;
  logic [2:0] busy_v, done_v, eq_v, gt_v, lt_v;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   idx;
    logic eq;
    logic gt;
    logic lt;
    int   done_cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compare_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
    .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0]));

  compare_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
    .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1]));

  compare_seq #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]),
    .eq(eq_v[2]), .gt(gt_v[2]), .lt(lt_v[2]));

  // Reference: flags from a plain full-width compare, latency from the
  // position of the most significant differing bit.
  function automatic exp_t model(input int idx, input logic [7:0] ma,
                                 input logic [7:0] mb, input logic sm,
                                 input int now);
    exp_t e;
    int   digit;
    int   n;
    int   k;
    int   lat;
    digit = (idx == 2) ? 4 : 1;
    n     = 8 / digit;
    k     = -1;
    for (int i = 7; i >= 0; i--) begin
      if (ma[i] != mb[i]) begin
        k = (7 - i) / digit;
        break;
      end
    end
    if (sm) begin
      e.gt = ($signed(ma) > $signed(mb));
      e.lt = ($signed(ma) < $signed(mb));
    end else begin
      e.gt = (ma > mb);
      e.lt = (ma < mb);
    end
    e.eq  = (ma == mb);
    lat   = ((idx != 1) && (k >= 0)) ? (k + 2) : (n + 1);
    e.idx = idx;
    e.done_cyc = now + lat;
    return e;
  endfunction

  // Called in the accept cycle T; returns in cycle T+1.
  task automatic drive_start(input int idx, input logic [7:0] da,
                             input logic [7:0] db, input logic sm);
    a           = da;
    b           = db;
    signed_mode = sm;
    start_v[idx] = 1'b1;
    exp_q.push_back(model(idx, da, db, sm, cyc));
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  // Follows a run until done, checks busy each cycle, then checks the
  // cycle after done. Returns in the cycle after done.
  task automatic wait_check(input int idx, input string name);
    exp_t e;
    bit   seen;
    bit   first;
    seen  = 1'b0;
    first = 1'b1;
    for (int t = 0; t < 30; t++) begin
      n_tests++;
      if (busy_v[idx] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy: got %b want 1 (cycle %0d)", name, busy_v[idx], cyc);
      end
      if (done_v[idx] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (first) begin
        n_tests++;
        if ({eq_v[idx], gt_v[idx], lt_v[idx]} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s flags_cleared: got %b want 000",
                   name, {eq_v[idx], gt_v[idx], lt_v[idx]});
        end
        first = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done within 30 cycles", name);
      return;
    end
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: done with no expected entry", name);
      return;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (e.idx != idx || cyc != e.done_cyc) begin
      n_fail++;
      $display("FAIL %s latency: done at cycle %0d want %0d (inst %0d/%0d)",
               name, cyc, e.done_cyc, idx, e.idx);
    end
    n_tests++;
    if ({eq_v[idx], gt_v[idx], lt_v[idx]} !== {e.eq, e.gt, e.lt}) begin
      n_fail++;
      $display("FAIL %s flags: eq/gt/lt got %b want %b",
               name, {eq_v[idx], gt_v[idx], lt_v[idx]}, {e.eq, e.gt, e.lt});
    end
    @(negedge clk);
    n_tests++;
    if (busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: busy/done got %b%b want 00",
               name, busy_v[idx], done_v[idx]);
    end
    n_tests++;
    if ({eq_v[idx], gt_v[idx], lt_v[idx]} !== {e.eq, e.gt, e.lt}) begin
      n_fail++;
      $display("FAIL %s flags_hold: got %b want %b",
               name, {eq_v[idx], gt_v[idx], lt_v[idx]}, {e.eq, e.gt, e.lt});
    end
  endtask

  task automatic expect_quiet(input int idx, input int cycles, input string name);
    for (int t = 0; t < cycles; t++) begin
      n_tests++;
      if (done_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s quiet: busy/done got %b%b want 00 (cycle %0d)",
                 name, busy_v[idx], done_v[idx], cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy_v, done_v, eq_v, gt_v, lt_v} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy,done,eq,gt,lt got %b want 0",
               {busy_v, done_v, eq_v, gt_v, lt_v});
    end
    rst = 1'b0;
    @(negedge clk);
    expect_quiet(0, 4, "reset_idle");
  endtask

  task automatic test_equal();
    @(negedge clk);
    drive_start(0, 8'hA5, 8'hA5, 1'b0);
    wait_check(0, "equal_a5");
    @(negedge clk);
    drive_start(2, 8'hA5, 8'hA5, 1'b0);
    wait_check(2, "equal_a5_d4");
  endtask

  task automatic test_msb_diff();
    @(negedge clk);
    drive_start(0, 8'h80, 8'h7F, 1'b0);
    wait_check(0, "msb_unsigned");
    @(negedge clk);
    drive_start(0, 8'h80, 8'h7F, 1'b1);
    wait_check(0, "msb_signed");
    @(negedge clk);
    drive_start(1, 8'h80, 8'h7F, 1'b0);
    wait_check(1, "msb_no_early_exit");
  endtask

  task automatic test_last_digit();
    @(negedge clk);
    drive_start(0, 8'h12, 8'h13, 1'b0);
    wait_check(0, "last_digit");
  endtask

  task automatic test_interference();
    @(negedge clk);
    drive_start(0, 8'h12, 8'h13, 1'b0);
    @(negedge clk);
    a = 8'h00;
    b = 8'hFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_check(0, "start_while_busy");
    expect_quiet(0, 12, "start_while_busy_no_rerun");
  endtask

  task automatic test_reset_abort();
    exp_t dummy;
    @(negedge clk);
    drive_start(0, 8'h12, 8'h13, 1'b0);
    dummy = exp_q.pop_back();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy,done,eq,gt,lt got %b want 00000 (aborted %0d)",
               {busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]}, dummy.done_cyc);
    end
    expect_quiet(0, 12, "reset_abort_no_done");
    // rst and start together: start is dropped
    rst = 1'b1;
    a   = 8'h01;
    b   = 8'h02;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    expect_quiet(0, 6, "rst_with_start");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_start(2, 8'h3C, 8'h3D, 1'b0);
    wait_check(2, "d4_low_digit");
    drive_start(2, 8'hF0, 8'h0F, 1'b1);
    wait_check(2, "d4_back_to_back_signed");
  endtask

  task automatic test_random();
    int          idx;
    logic [7:0]  ra, rb;
    logic        sm;
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 2);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      sm  = 1'($urandom);
      @(negedge clk);
      drive_start(idx, ra, rb, sm);
      wait_check(idx, "random");
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_v     = 3'b000;
    signed_mode = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    test_reset();
    test_equal();
    test_msb_diff();
    test_last_digit();
    test_interference();
    test_reset_abort();
    test_back_to_back();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_compare_seq
